// File: rtl/usb_line_pkg.sv
// Shared types and default 48 MHz timing constants for the USB line-control block.
package usb_line_pkg;

    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_K   = 2'b01,
        LS_J   = 2'b10,
        LS_SE1 = 2'b11
    } line_state_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_GAP,
        ST_RESUME,
        ST_DETACH,
        ST_RELEASE
    } fsm_state_e;

    localparam int DEF_RESET_CYCLES   = 120;
    localparam int DEF_SUSPEND_CYCLES = 144000;
    localparam int DEF_RESUME_CYCLES  = 96000;
    localparam int DEF_GAP_CYCLES     = 16;
    localparam int DEF_CNT_W          = 18;

    // Pin pair {p, n} maps directly onto the enum encoding.
    function automatic line_state_e decode_line(input logic p, input logic n);
        return line_state_e'({p, n});
    endfunction

endpackage

// File: rtl/usb_line_detect.sv
// Received line-state monitor: two-flop sync, J/K/SE0/SE1 decode, and the
// saturating SE0/idle counters that raise bus_reset and suspend.
module usb_line_detect
    import usb_line_pkg::*;
#(
    parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
    parameter int SUSPEND_CYCLES = DEF_SUSPEND_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic clk_48mhz,
    input  logic reset_n,
    input  logic phy_p_rx,
    input  logic phy_n_rx,
    input  logic tx_active,
    input  logic clr_suspend,
    output logic bus_reset,
    output logic suspend
);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] RESET_TH   = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] SUSPEND_TH = CNT_W'(SUSPEND_CYCLES);

    logic [1:0]       rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
    logic [CNT_W-1:0] se0_cnt_q, se0_cnt_d, idle_cnt_q, idle_cnt_d;
    logic             bus_reset_q, bus_reset_d, suspend_q, suspend_d;
    line_state_e      line;

    always_comb begin
        rx_s1_d     = {phy_p_rx, phy_n_rx};
        rx_s2_d     = rx_s1_q;
        line        = decode_line(rx_s2_q[1], rx_s2_q[0]);
        se0_cnt_d   = '0;
        idle_cnt_d  = '0;
        bus_reset_d = 1'b0;
        suspend_d   = 1'b0;
        // Our own transmit loops back as J, so the monitors sit cleared meanwhile.
        if (!tx_active) begin
            if (line == LS_SE0) begin
                se0_cnt_d   = (se0_cnt_q == CNT_MAX) ? se0_cnt_q : se0_cnt_q + 1'b1;
                bus_reset_d = bus_reset_q || (se0_cnt_d >= RESET_TH);
            end
            if (line == LS_J && !clr_suspend) begin
                idle_cnt_d = (idle_cnt_q == CNT_MAX) ? idle_cnt_q : idle_cnt_q + 1'b1;
                suspend_d  = suspend_q || (idle_cnt_d >= SUSPEND_TH);
            end
        end
    end

    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) begin
            rx_s1_q     <= LS_J;
            rx_s2_q     <= LS_J;
            se0_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            bus_reset_q <= 1'b0;
            suspend_q   <= 1'b0;
        end else begin
            rx_s1_q     <= rx_s1_d;
            rx_s2_q     <= rx_s2_d;
            se0_cnt_q   <= se0_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            bus_reset_q <= bus_reset_d;
            suspend_q   <= suspend_d;
        end
    end

    assign bus_reset = bus_reset_q;
    assign suspend   = suspend_q;

endmodule

// File: rtl/usb_line_ctrl.sv
// Line-control sequencer / PHY arbiter between SIE and PHY pads.
// Remote wakeup (RESUME state) is built only when USB_LINE_RESUME_EN is defined.
module usb_line_ctrl
    import usb_line_pkg::*;
#(
    parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
    parameter int SUSPEND_CYCLES = DEF_SUSPEND_CYCLES,
    parameter int RESUME_CYCLES  = DEF_RESUME_CYCLES,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic clk_48mhz,
    input  logic reset_n,
    input  logic sie_p_tx,
    input  logic sie_n_tx,
    input  logic sie_tx_en,
    output logic phy_p_tx,
    output logic phy_n_tx,
    output logic phy_tx_en,
    input  logic phy_p_rx,
    input  logic phy_n_rx,
    input  logic resume_req,
    input  logic detach_req,
    output logic line_busy,
    output logic collision,
    output logic bus_reset,
    output logic suspend
);

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    fsm_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phy_p_q, phy_p_d, phy_n_q, phy_n_d, phy_en_q, phy_en_d;
    logic             busy_q, busy_d, collision_q, collision_d;
    logic             resume_pend, enter_resume;

    usb_line_detect #(
        .RESET_CYCLES  (RESET_CYCLES),
        .SUSPEND_CYCLES(SUSPEND_CYCLES),
        .CNT_W         (CNT_W)
    ) u_detect (
        .clk_48mhz  (clk_48mhz),
        .reset_n    (reset_n),
        .phy_p_rx   (phy_p_rx),
        .phy_n_rx   (phy_n_rx),
        .tx_active  (phy_en_q),
        .clr_suspend(enter_resume),
        .bus_reset  (bus_reset),
        .suspend    (suspend)
    );

`ifdef USB_LINE_RESUME_EN
    localparam logic [CNT_W-1:0] RESUME_LAST = CNT_W'(RESUME_CYCLES - 1);
    logic pend_q, pend_d;

    always_comb begin
        pend_d = pend_q;
        if (resume_req && suspend) pend_d = 1'b1;
        if (enter_resume)          pend_d = 1'b0;
    end

    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) pend_q <= 1'b0;
        else          pend_q <= pend_d;
    end

    assign resume_pend = pend_q;
`else
    logic unused_resume;
    assign unused_resume = resume_req ^ (RESUME_CYCLES > 0);
    assign resume_pend   = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        phy_p_d      = 1'b1;
        phy_n_d      = 1'b0;
        phy_en_d     = 1'b0;
        enter_resume = 1'b0;
        collision_d  = sie_tx_en && (state_q == ST_RESUME || state_q == ST_DETACH ||
                                     state_q == ST_RELEASE);
        case (state_q)
            ST_IDLE: begin
                {phy_p_d, phy_n_d, phy_en_d} = {sie_p_tx, sie_n_tx, sie_tx_en};
                if (detach_req || resume_pend) begin
                    state_d = ST_WAIT_GAP;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_GAP: begin
                if (sie_tx_en) begin
                    // SIE got there first: hand the line back, request stays pending.
                    state_d = ST_IDLE;
                    {phy_p_d, phy_n_d, phy_en_d} = {sie_p_tx, sie_n_tx, sie_tx_en};
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (detach_req) begin
                        state_d = ST_DETACH;
                        {phy_p_d, phy_n_d, phy_en_d} = 3'b001;
`ifdef USB_LINE_RESUME_EN
                    end else if (resume_pend) begin
                        state_d      = ST_RESUME;
                        enter_resume = 1'b1;
                        {phy_p_d, phy_n_d, phy_en_d} = 3'b011;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef USB_LINE_RESUME_EN
            ST_RESUME: begin
                if (cnt_q == RESUME_LAST) begin
                    state_d = ST_RELEASE;
                    {phy_p_d, phy_n_d, phy_en_d} = 3'b101;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    {phy_p_d, phy_n_d, phy_en_d} = 3'b011;
                end
            end
`endif
            ST_DETACH: begin
                if (detach_req) begin
                    {phy_p_d, phy_n_d, phy_en_d} = 3'b001;
                end else begin
                    state_d = ST_RELEASE;
                    {phy_p_d, phy_n_d, phy_en_d} = 3'b101;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            phy_p_q     <= 1'b1;
            phy_n_q     <= 1'b0;
            phy_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phy_p_q     <= phy_p_d;
            phy_n_q     <= phy_n_d;
            phy_en_q    <= phy_en_d;
            busy_q      <= busy_d;
            collision_q <= collision_d;
        end
    end

    assign phy_p_tx  = phy_p_q;
    assign phy_n_tx  = phy_n_q;
    assign phy_tx_en = phy_en_q;
    assign line_busy = busy_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_usb_line_ctrl.sv
// Self-checking bench for usb_line_ctrl with shortened timing constants.
module tb_usb_line_ctrl;

    localparam int RST_N = 8;
    localparam int SUS_N = 32;
    localparam int RES_N = 20;
    localparam int GAP_N = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sie_p_tx = 1'b1, sie_n_tx = 1'b0, sie_tx_en = 1'b0;
    logic phy_p_tx, phy_n_tx, phy_tx_en;
    logic [1:0] rx = 2'b10;
    logic resume_req = 1'b0, detach_req = 1'b0;
    logic line_busy, collision, bus_reset, suspend;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    usb_line_ctrl #(
        .RESET_CYCLES  (RST_N),
        .SUSPEND_CYCLES(SUS_N),
        .RESUME_CYCLES (RES_N),
        .GAP_CYCLES    (GAP_N),
        .CNT_W         (18)
    ) dut (
        .clk_48mhz (clk),
        .reset_n   (reset_n),
        .sie_p_tx  (sie_p_tx),
        .sie_n_tx  (sie_n_tx),
        .sie_tx_en (sie_tx_en),
        .phy_p_tx  (phy_p_tx),
        .phy_n_tx  (phy_n_tx),
        .phy_tx_en (phy_tx_en),
        .phy_p_rx  (rx[1]),
        .phy_n_rx  (rx[0]),
        .resume_req(resume_req),
        .detach_req(detach_req),
        .line_busy (line_busy),
        .collision (collision),
        .bus_reset (bus_reset),
        .suspend   (suspend)
    );

    typedef struct {
        logic [2:0] sie;      // {p, n, tx_en}
        logic [2:0] exp_phy;
        logic       exp_busy;
    } vec_t;

    vec_t tbl[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int phy3();
        return int'({phy_p_tx, phy_n_tx, phy_tx_en});
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        rx = 2'b10;
        {sie_p_tx, sie_n_tx, sie_tx_en} = 3'b100;
        resume_req = 1'b0;
        detach_req = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic pulse_resume();
        resume_req = 1'b1;
        step();
        resume_req = 1'b0;
    endtask

    initial begin
        logic [1:0] pin_m1, pin_m2, seg_state;
        logic       tx_prev;
        int         se0_run, j_run, seg_left, r;
        logic [2:0] rs;

        // Reset state
        do_reset();
        check("reset_phy", phy3(), 3'b100);
        check("reset_busy", line_busy, 0);
        check("reset_collision", collision, 0);
        check("reset_bus_reset", bus_reset, 0);
        check("reset_suspend", suspend, 0);

        // IDLE forwarding table
        tbl[0] = '{3'b011, 3'b011, 1'b0};
        tbl[1] = '{3'b101, 3'b101, 1'b0};
        tbl[2] = '{3'b001, 3'b001, 1'b0};
        tbl[3] = '{3'b110, 3'b110, 1'b0};
        tbl[4] = '{3'b100, 3'b100, 1'b0};
        tbl[5] = '{3'b011, 3'b011, 1'b0};
        for (int i = 0; i < 6; i++) begin
            {sie_p_tx, sie_n_tx, sie_tx_en} = tbl[i].sie;
            step();
            check($sformatf("fwd_phy[%0d]", i), phy3(), tbl[i].exp_phy);
            check($sformatf("fwd_busy[%0d]", i), line_busy, tbl[i].exp_busy);
        end
        {sie_p_tx, sie_n_tx, sie_tx_en} = 3'b100;
        step();
        step();

        // Short SE0 burst (one below threshold) must not flag bus reset
        rx = 2'b00;
        for (int k = 1; k <= RST_N - 1; k++) begin
            step();
            check($sformatf("short_se0_k%0d", k), bus_reset, 0);
        end
        rx = 2'b10;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("short_se0_tail_k%0d", k), bus_reset, 0);
        end

        // Held SE0: bus_reset rises exactly RST_N+2 edges after first SE0
        rx = 2'b00;
        for (int k = 1; k <= RST_N + 2; k++) begin
            step();
            check($sformatf("se0_k%0d", k), bus_reset, (k >= RST_N + 2) ? 1 : 0);
        end
        // Back to J: bus_reset clears on the third edge, suspend rises at SUS_N+2
        rx = 2'b10;
        for (int k = 1; k <= SUS_N + 2; k++) begin
            step();
            if (k <= 3)
                check($sformatf("br_clear_k%0d", k), bus_reset, (k < 3) ? 1 : 0);
            if (k >= SUS_N + 1)
                check($sformatf("suspend_k%0d", k), suspend, (k >= SUS_N + 2) ? 1 : 0);
        end

`ifdef USB_LINE_RESUME_EN
        // Remote wakeup: pending at k=0, WAIT_GAP k=1..4, K k=5..24, J k=25, released k=26
        resume_req = 1'b1;
        for (int k = 0; k <= 26; k++) begin
            step();
            resume_req = 1'b0;
            rs = (k >= 5 && k <= 24) ? 3'b011 : (k == 25) ? 3'b101 : 3'b100;
            check($sformatf("resume_phy_k%0d", k), phy3(), rs);
            check($sformatf("resume_busy_k%0d", k), line_busy, (k >= 1 && k <= 25) ? 1 : 0);
            if (k == 4) check("resume_suspend_pre", suspend, 1);
            if (k == 5) check("resume_suspend_entry", suspend, 0);
            check($sformatf("resume_coll_k%0d", k), collision, 0);
        end
`else
        // Without remote wakeup, resume_req is ignored even while suspended
        pulse_resume();
        for (int k = 1; k <= 10; k++) begin
            check($sformatf("noresume_busy_k%0d", k), line_busy, 0);
            check($sformatf("noresume_tx_k%0d", k), phy_tx_en, 0);
            step();
        end
`endif

        // resume_req while not suspended is dropped
        rx = 2'b01;
        step(); step(); step();
        check("nosusp_suspend", suspend, 0);
        pulse_resume();
        for (int k = 1; k <= 10; k++) begin
            check($sformatf("nosusp_busy_k%0d", k), line_busy, 0);
            step();
        end

        // Detach raised while SIE transmitting: bounce, then SE0 after GAP_N idle cycles
        rx = 2'b10;
        {sie_p_tx, sie_n_tx, sie_tx_en} = 3'b101;
        detach_req = 1'b1;
        step(); step(); step();
        sie_tx_en = 1'b0;
        for (int k = 1; k <= GAP_N; k++) begin
            step();
            if (k < GAP_N) begin
                check($sformatf("detach_gap_tx_k%0d", k), phy_tx_en, 0);
                check($sformatf("detach_gap_busy_k%0d", k), line_busy, 1);
            end else begin
                check("detach_se0", phy3(), 3'b001);
            end
        end
        // SIE transmit during DETACH: collision pulse, line still SE0
        sie_tx_en = 1'b1;
        step();
        sie_tx_en = 1'b0;
        check("collision_pulse", collision, 1);
        check("collision_phy", phy3(), 3'b001);
        step();
        check("collision_end", collision, 0);
        check("detach_hold", phy3(), 3'b001);
        detach_req = 1'b0;
        step();
        check("release_phy", phy3(), 3'b101);
        check("release_busy", line_busy, 1);
        step();
        check("post_release_tx", phy_tx_en, 0);
        check("post_release_busy", line_busy, 0);

        // Reset asserted mid-DETACH
        detach_req = 1'b1;
        for (int k = 0; k < GAP_N + 3; k++) step();
        check("mid_detach_phy", phy3(), 3'b001);
        reset_n = 1'b0;
        detach_req = 1'b0;
        step();
        check("rst_detach_tx", phy_tx_en, 0);
        check("rst_detach_busy", line_busy, 0);
        check("rst_detach_flags", int'({collision, bus_reset, suspend}), 0);
        reset_n = 1'b1;
        step();
        check("rst_detach_after_busy", line_busy, 0);

`ifdef USB_LINE_RESUME_EN
        // Reset asserted mid-RESUME discards the wakeup request
        rx = 2'b10;
        for (int k = 0; k < SUS_N + 6; k++) step();
        check("mid_resume_suspend", suspend, 1);
        pulse_resume();
        for (int k = 0; k < 10; k++) step();
        check("mid_resume_phy", phy3(), 3'b011);
        reset_n = 1'b0;
        step();
        check("rst_resume_tx", phy_tx_en, 0);
        check("rst_resume_busy", line_busy, 0);
        check("rst_resume_flags", int'({collision, bus_reset, suspend}), 0);
        reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("rst_resume_idle_k%0d", k), line_busy, 0);
        end
`endif

        // Randomised line traffic with SIE forwarding, checked against run-length model
        do_reset();
        pin_m1 = 2'b10;
        pin_m2 = 2'b10;
        tx_prev = 1'b0;
        se0_run = 0;
        j_run = 0;
        seg_left = 0;
        seg_state = 2'b10;
        for (int c = 0; c < 1500; c++) begin
            if (seg_left == 0) begin
                r = $urandom_range(0, 9);
                seg_state = (r < 4) ? 2'b10 : (r < 8) ? 2'b00 : (r == 8) ? 2'b01 : 2'b11;
                seg_left = $urandom_range(1, 45);
            end
            seg_left--;
            rx = seg_state;
            sie_p_tx = 1'($urandom_range(0, 1));
            sie_n_tx = 1'($urandom_range(0, 1));
            sie_tx_en = ($urandom_range(0, 39) == 0);
            step();
            // The monitors see the pins from two edges back, gated by last cycle's tx_en.
            se0_run = (pin_m2 == 2'b00 && !tx_prev) ? se0_run + 1 : 0;
            j_run   = (pin_m2 == 2'b10 && !tx_prev) ? j_run + 1 : 0;
            check($sformatf("rnd_bus_reset_c%0d", c), bus_reset, (se0_run >= RST_N) ? 1 : 0);
            check($sformatf("rnd_suspend_c%0d", c), suspend, (j_run >= SUS_N) ? 1 : 0);
            check($sformatf("rnd_phy_c%0d", c), phy3(), int'({sie_p_tx, sie_n_tx, sie_tx_en}));
            check($sformatf("rnd_busy_c%0d", c), line_busy, 0);
            pin_m2 = pin_m1;
            pin_m1 = seg_state;
            tx_prev = sie_tx_en;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
